// File: rtl/pb_event_classifier.sv
// Push-button gesture classifier: turns debounced press/release pulses into
// single-click, double-click, long-press and auto-repeat one-cycle pulses.
module pb_event_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int TIMER_WIDTH   = $clog2(
    (LONG_CYCLES > GAP_CYCLES)
      ? ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES)
      : ((GAP_CYCLES  > REPEAT_CYCLES) ? GAP_CYCLES  : REPEAT_CYCLES)) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pressed_pulse,
  input  logic released_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HELD
  } state_t;

  // Terminal counts: the deciding edge sees timer == N-1, i.e. N cycles in state.
  localparam logic [TIMER_WIDTH-1:0] LONG_LAST   = TIMER_WIDTH'(LONG_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] GAP_LAST    = TIMER_WIDTH'(GAP_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] REPEAT_LAST = TIMER_WIDTH'(REPEAT_CYCLES - 1);

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [TIMER_WIDTH-1:0] timer_inc;

  // Saturating increment so a stuck state can never wrap into a false match.
  assign timer_inc = (timer == '1) ? timer : timer + TIMER_WIDTH'(1);

  assign busy = (state != IDLE);

  // NOTE: every register here uses non-blocking assignment so all flops see
  // the pre-edge values of state/timer, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;

      if (!en) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            timer <= '0;
            if (pressed_pulse) state <= PRESS1;
          end

          PRESS1: begin
            if (released_pulse) begin
              state <= WAIT_GAP;
              timer <= '0;
            end else if (timer == LONG_LAST) begin
              state      <= LONG_HELD;
              timer      <= '0;
              long_press <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
          end

          WAIT_GAP: begin
            if (pressed_pulse) begin
              state <= PRESS2;
              timer <= '0;
            end else if (timer == GAP_LAST) begin
              state        <= IDLE;
              timer        <= '0;
              single_click <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
          end

          // Second press is a double click however long it is held.
          PRESS2: begin
            timer <= '0;
            if (released_pulse) begin
              state        <= IDLE;
              double_click <= 1'b1;
            end
          end

          LONG_HELD: begin
            if (released_pulse) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == REPEAT_LAST) begin
              timer        <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
          end

          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pb_event_classifier.sv
// Directed bench for pb_event_classifier with short timing parameters.
// Cycle n is the interval ending at edge n; outputs are sampled on the falling edge.
module tb_pb_event_classifier;

  localparam int LONG   = 8;
  localparam int GAP    = 5;
  localparam int REPEAT = 4;
  localparam int NCYC   = 47;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic pressed_pulse;
  logic released_pulse;
  logic single_click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  int tests  = 0;
  int failed = 0;

  pb_event_classifier #(
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAP),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse),
    .single_click  (single_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Bit n of each mask refers to edge n (stimulus) or cycle n (expectation).
  typedef struct {
    string       name;
    logic [63:0] press;
    logic [63:0] rel;
    logic [63:0] en_low;
    logic [63:0] single;
    logic [63:0] dbl;
    logic [63:0] lng;
    logic [63:0] rep;
    logic [63:0] bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] b(input int n);
    return 64'(1) << n;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic add(input string name, input logic [63:0] press, rel, en_low,
                     single, dbl, lng, rep, bsy);
    vec_t v;
    v.name = name; v.press = press; v.rel = rel; v.en_low = en_low;
    v.single = single; v.dbl = dbl; v.lng = lng; v.rep = rep; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  // Compared vector order: {single, double, long, repeat, busy}.
  task automatic check(input string name, input int cyc, input logic [4:0] exp);
    logic [4:0] act;
    act = {single_click, double_click, long_press, repeat_pulse, busy};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got {sgl,dbl,lng,rep,busy}=%b expected %b",
               name, cyc, act, exp);
    end
  endtask

  // Leaves the bench at a falling edge with the next rising edge being edge 1.
  task automatic apply_reset();
    rst = 1'b0; en = 1'b1; pressed_pulse = 1'b0; released_pulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    apply_reset();
    for (int n = 1; n <= NCYC; n++) begin
      check(v.name, n, {v.single[n], v.dbl[n], v.lng[n], v.rep[n], v.bsy[n]});
      pressed_pulse  = v.press[n];
      released_pulse = v.rel[n];
      en             = ~v.en_low[n];
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; pressed_pulse = 1'b0; released_pulse = 1'b0;

    //   name              press                 release                     en_low       single        double  long   repeat        busy
    add("single",          b(10),                b(13),                      '0,          b(19),        '0,     '0,    '0,           span(11,18));
    add("double",          b(10)|b(15),          b(12)|b(20),                '0,          '0,           b(21),  '0,    '0,           span(11,20));
    add("long_repeat",     b(10),                b(30),                      '0,          '0,           '0,     b(19), b(23)|b(27),  span(11,30));
    add("rel_long_m2",     b(10),                b(17),                      '0,          b(23),        '0,     '0,    '0,           span(11,22));
    add("rel_long_edge",   b(10),                b(18),                      '0,          b(24),        '0,     '0,    '0,           span(11,23));
    add("rel_after_long",  b(10),                b(19),                      '0,          '0,           '0,     b(19), '0,           span(11,19));
    add("press_gap_m2",    b(10)|b(16),          b(12)|b(18),                '0,          '0,           b(19),  '0,    '0,           span(11,18));
    add("press_gap_edge",  b(10)|b(17),          b(12)|b(18),                '0,          '0,           b(19),  '0,    '0,           span(11,18));
    add("gap_expire_rep",  b(10)|b(18),          b(12)|b(20),                '0,          b(18)|b(26),  '0,     '0,    '0,           span(11,17)|span(19,25));
    add("press2_no_tmo",   b(10)|b(14),          b(12)|b(40),                '0,          '0,           b(41),  '0,    '0,           span(11,40));
    add("simultaneous",    b(10)|b(13)|b(15),    b(10)|b(13)|b(15)|b(17),    '0,          '0,           b(18),  '0,    '0,           span(11,17));
    add("rep_vs_release",  b(10),                b(26),                      '0,          '0,           '0,     b(19), b(23),        span(11,26));
    add("en_gate",         b(10)|b(20),          b(12)|b(22),                span(1,15),  b(28),        '0,     '0,    '0,           span(21,27));
    add("en_mid_press",    b(10),                b(16),                      b(13),       '0,           '0,     '0,    '0,           span(11,13));
    add("en_long_held",    b(10),                b(25),                      b(20),       '0,           '0,     b(19), '0,           span(11,20));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a press discards the gesture.
    apply_reset();
    for (int n = 1; n <= 13; n++) begin
      check("rst_mid_pre", n, {4'b0000, (n >= 11)});
      pressed_pulse = (n == 10);
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_mid_busy", 14, 5'b00001);
    rst = 1'b0;
    #1;
    check("rst_mid_async", 14, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    for (int n = 15; n <= 40; n++) begin
      if (n == 16) rst = 1'b1;
      check("rst_mid_post", n, 5'b00000);
      released_pulse = (n == 18);
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
